// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift of one
// command byte with odd parity and stop, ACK check and frame timeout. Drives lines low only.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drv_low,
  output logic       ps2_data_drv_low,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, INHIBIT, SHIFT, WAIT_IDLE} state_t;

  state_t           state;
  logic [7:0]       shift_reg;
  logic             parity;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inhibit_cnt;
  logic [19:0]      timer;
  logic             ack_ok;

  logic clk_s1, clk_sync, clk_prev;
  logic data_s1, data_sync;
  logic clk_fall;

  // Synchronisers reset to the idle (released) level so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1    <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_s1   <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_s1    <= ps2_clk_in;
      clk_sync  <= clk_s1;
      clk_prev  <= clk_sync;
      data_s1   <= ps2_data_in;
      data_sync <= data_s1;
    end
  end

  assign clk_fall   = clk_prev & ~clk_sync;
  assign tx_ready   = (state == IDLE);
  assign rx_inhibit = ~tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      shift_reg        <= '0;
      parity           <= 1'b0;
      bit_cnt          <= '0;
      inhibit_cnt      <= '0;
      timer            <= '0;
      ack_ok           <= 1'b0;
      ps2_clk_drv_low  <= 1'b0;
      ps2_data_drv_low <= 1'b0;
      done             <= 1'b0;
      ack_err          <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      done    <= 1'b0;
      ack_err <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shift_reg       <= tx_data;
            parity          <= ~^tx_data;
            bit_cnt         <= '0;
            inhibit_cnt     <= '0;
            ps2_clk_drv_low <= 1'b1;
            state           <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inhibit_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_drv_low  <= 1'b0;
            ps2_data_drv_low <= 1'b1;
            timer            <= '0;
            state            <= SHIFT;
          end else begin
            inhibit_cnt <= inhibit_cnt + 1'b1;
          end
        end
        SHIFT: begin
          timer <= timer + 20'd1;
          // Timeout wins over a falling edge landing on the same cycle.
          if (timer == 20'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_drv_low  <= 1'b0;
            ps2_data_drv_low <= 1'b0;
            timeout          <= 1'b1;
            state            <= IDLE;
          end else if (clk_fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              ps2_data_drv_low <= ~shift_reg[0];
              shift_reg        <= {1'b0, shift_reg[7:1]};
            end else if (bit_cnt == 4'd8) begin
              ps2_data_drv_low <= ~parity;
            end else if (bit_cnt == 4'd9) begin
              ps2_data_drv_low <= 1'b0;
            end else begin
              ps2_data_drv_low <= 1'b0;
              ack_ok           <= ~data_sync;
              state            <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          timer <= timer + 20'd1;
          if (timer == 20'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_drv_low  <= 1'b0;
            ps2_data_drv_low <= 1'b0;
            timeout          <= 1'b1;
            state            <= IDLE;
          end else if (clk_sync && data_sync) begin
            done    <= ack_ok;
            ack_err <= ~ack_ok;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed self-checking bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_drv_low;
  logic       ps2_data_drv_low;
  logic       rx_inhibit;
  logic       done;
  logic       ack_err;
  logic       timeout;

  logic dev_clk_low;
  logic dev_data_low;
  logic ps2_clk_line;
  logic ps2_data_line;

  int n_checks;
  int n_fail;
  int done_cnt;
  int ack_err_cnt;
  int timeout_cnt;

  logic [7:0] got_byte;
  logic       got_par;
  logic       got_stop;
  logic       got_start;
  int         inh_len;
  bit         timed_out;
  int         wait_n;

  // Wired-AND of host and device open-drain pulls with pull-up resistors.
  assign ps2_clk_line  = ~(ps2_clk_drv_low | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_drv_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(10),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .ps2_clk_in      (ps2_clk_line),
    .ps2_data_in     (ps2_data_line),
    .ps2_clk_drv_low (ps2_clk_drv_low),
    .ps2_data_drv_low(ps2_data_drv_low),
    .rx_inhibit      (rx_inhibit),
    .done            (done),
    .ack_err         (ack_err),
    .timeout         (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)    done_cnt++;
    if (ack_err) ack_err_cnt++;
    if (timeout) timeout_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: measure inhibit, clock the frame in, optionally ACK. abort_at > 0 stops with
  // the device clock held low at that falling edge.
  task automatic dev_frame(input bit ack, input int abort_at, output logic [7:0] b,
                           output logic par, output logic stop, output logic start,
                           output int inh, output bit to);
    int   n;
    logic s;
    b = '0; par = 1'b0; stop = 1'b0; start = 1'b0; inh = 0; n = 0;
    while (ps2_clk_drv_low !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (ps2_clk_drv_low === 1'b1 && inh < 200) begin
      inh++;
      @(negedge clk);
    end
    to    = (n >= 200) || (inh >= 200);
    start = ~ps2_data_line;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      if (k == abort_at) return;
      s = ps2_data_line;
      dev_clk_low = 1'b0;
      if (k <= 8) b[k-1] = s;
      else if (k == 9) par = s;
      else stop = s;
      repeat (20) @(negedge clk);
    end
    if (ack) dev_data_low = 1'b1;
    repeat (10) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_ready(output bit to);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    to = (tx_ready !== 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_tx_ready", tx_ready, 1);
    check_output("rst_rx_inhibit", rx_inhibit, 0);
    check_output("rst_clk_drv", ps2_clk_drv_low, 0);
    check_output("rst_data_drv", ps2_data_drv_low, 0);
    check_output("rst_pulses", {done, ack_err, timeout}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: 0xED with ACK
    apply_stimulus(8'hED);
    check_output("t1_rx_inhibit", rx_inhibit, 1);
    dev_frame(1'b1, 0, got_byte, got_par, got_stop, got_start, inh_len, timed_out);
    check_output("t1_wait", timed_out, 0);
    check_output("t1_inhibit_len", inh_len, 10);
    check_output("t1_start", got_start, 1);
    check_output("t1_byte", got_byte, 8'hED);
    check_output("t1_parity", got_par, 1);
    check_output("t1_stop", got_stop, 1);
    wait_ready(timed_out);
    check_output("t1_idle_wait", timed_out, 0);
    repeat (2) @(negedge clk);
    check_output("t1_done_cnt", done_cnt, 1);
    check_output("t1_ack_err_cnt", ack_err_cnt, 0);

    // 2: 0x07 with ACK
    apply_stimulus(8'h07);
    dev_frame(1'b1, 0, got_byte, got_par, got_stop, got_start, inh_len, timed_out);
    check_output("t2_byte", got_byte, 8'h07);
    check_output("t2_parity", got_par, 0);
    wait_ready(timed_out);
    check_output("t2_idle_wait", timed_out, 0);
    repeat (2) @(negedge clk);
    check_output("t2_done_cnt", done_cnt, 2);
    check_output("t2_tx_ready", tx_ready, 1);

    // 3: 0x00 without ACK
    apply_stimulus(8'h00);
    dev_frame(1'b0, 0, got_byte, got_par, got_stop, got_start, inh_len, timed_out);
    check_output("t3_byte", got_byte, 8'h00);
    check_output("t3_parity", got_par, 1);
    wait_ready(timed_out);
    repeat (2) @(negedge clk);
    check_output("t3_ack_err_cnt", ack_err_cnt, 1);
    check_output("t3_done_cnt", done_cnt, 2);

    // 4: 0xFF, device silent
    apply_stimulus(8'hFF);
    wait_n = 0;
    while (ps2_clk_drv_low === 1'b1 && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    check_output("t4_start_drv", ps2_data_drv_low, 1);
    wait_n = 0;
    while (timeout !== 1'b1 && wait_n < 2100) begin
      @(negedge clk);
      wait_n++;
    end
    check_output("t4_timeout_delay", wait_n, 2000);
    check_output("t4_lines", {ps2_clk_drv_low, ps2_data_drv_low}, 0);
    check_output("t4_tx_ready", tx_ready, 1);
    repeat (5) @(negedge clk);
    check_output("t4_pulse_cnts", {done_cnt[7:0], ack_err_cnt[7:0], timeout_cnt[7:0]}, 24'h020101);

    // 5: 0x55 offered while 0xF4 is in flight
    @(negedge clk);
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h55;
    dev_frame(1'b1, 0, got_byte, got_par, got_stop, got_start, inh_len, timed_out);
    check_output("t5_first_byte", got_byte, 8'hF4);
    check_output("t5_first_parity", got_par, 0);
    wait_ready(timed_out);
    check_output("t5_idle_wait", timed_out, 0);
    wait_n = 0;
    while (tx_ready === 1'b1 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    tx_valid = 1'b0;
    check_output("t5_second_accept", tx_ready, 0);
    dev_frame(1'b1, 0, got_byte, got_par, got_stop, got_start, inh_len, timed_out);
    check_output("t5_second_byte", got_byte, 8'h55);
    check_output("t5_second_parity", got_par, 1);
    wait_ready(timed_out);
    repeat (2) @(negedge clk);
    check_output("t5_done_cnt", done_cnt, 4);

    // 6: async reset mid-frame, then a clean send
    apply_stimulus(8'hED);
    dev_frame(1'b1, 5, got_byte, got_par, got_stop, got_start, inh_len, timed_out);
    check_output("t6_bit4_drv", ps2_data_drv_low, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_lines", {ps2_clk_drv_low, ps2_data_drv_low}, 0);
    check_output("t6_rst_ready", tx_ready, 1);
    @(negedge clk);
    dev_clk_low = 1'b0;
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_output("t6_no_pulses", {done_cnt[7:0], ack_err_cnt[7:0], timeout_cnt[7:0]}, 24'h040101);
    apply_stimulus(8'hED);
    dev_frame(1'b1, 0, got_byte, got_par, got_stop, got_start, inh_len, timed_out);
    check_output("t6_resend_byte", got_byte, 8'hED);
    wait_ready(timed_out);
    repeat (2) @(negedge clk);
    check_output("t6_done_cnt", done_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
